// File: rtl/alu_pkg.sv
// Shared types and constants for the shared-ALU arbiter slice.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    localparam logic [DATA_W-1:0] ALU_ILLEGAL_RESULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; opcodes above XOR return a marker value and flag an error.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] y_c,
    output logic              err_c
);

    // Opcode decode; add/sub wrap naturally at the result width
    always_comb begin
        y_c   = '0;
        err_c = 1'b0;
        case (op)
            ALU_ADD: y_c = a + b;
            ALU_SUB: y_c = a - b;
            ALU_AND: y_c = a & b;
            ALU_OR:  y_c = a | b;
            ALU_XOR: y_c = a ^ b;
            default: begin
                y_c   = ALU_ILLEGAL_RESULT;
                err_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [ID_W-1:0]    idx_c,
    output logic               any_c
);

    // Scan NUM_REQ positions starting at ptr, keep the first hit
    always_comb begin
        int unsigned k;
        k     = 0;
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = 32'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!any_c && req[ID_W'(k)]) begin
                any_c             = 1'b1;
                idx_c             = ID_W'(k);
                gnt_c[ID_W'(k)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among NUM_REQ requesters: grant (IDLE) -> evaluate (EXEC) -> respond (RESP).
// Optional counters built when ALU_ARB_PERF_EN is defined.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
`ifdef ALU_ARB_PERF_EN
    output logic [31:0]               op_count,
    output logic [15:0]               err_count,
`endif
    output logic                      rsp_err
);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [OP_W-1:0]     op_q;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic [DATA_W-1:0]   alu_y;
    logic                alu_err;
    logic                grant_c;
    logic                rsp_done_c;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .gnt_c (gnt),
        .idx_c (gnt_idx),
        .any_c (gnt_any)
    );

    alu u_alu (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .y_c   (alu_y),
        .err_c (alu_err)
    );

    // Next state and handshake strobes; req_ready is only ever raised in IDLE
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        grant_c    = 1'b0;
        rsp_done_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && gnt_any) begin
                    req_ready = gnt;
                    grant_c   = 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready[id_q]) begin
                    rsp_done_c = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture, rr pointer, registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (grant_c) begin
                a_q      <= req_a[DATA_W*gnt_idx +: DATA_W];
                b_q      <= req_b[OP_W*0 + DATA_W*gnt_idx +: DATA_W];
                op_q     <= req_op[OP_W*gnt_idx +: OP_W];
                id_q     <= gnt_idx;
                rr_ptr_q <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
            end
            if (state_q == EXEC) begin
                rsp_data  <= alu_y;
                rsp_err   <= alu_err;
                rsp_valid <= NUM_REQ'(1) << id_q;
            end
            if (rsp_done_c) rsp_valid <= '0;
        end
    end

`ifdef ALU_ARB_PERF_EN
    // Completed-response counter (wraps) and illegal-op counter (saturates)
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count  <= '0;
            err_count <= '0;
        end else if (rsp_done_c) begin
            op_count <= op_count + 32'd1;
            if (rsp_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with an expected-response queue.
module tb_alu_share_arb;

    localparam int unsigned N = 4;

    typedef struct packed {
        logic [N-1:0]  vld;
        logic [31:0]   data;
        logic          err;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*32-1:0]  req_a;
    logic [N*32-1:0]  req_b;
    logic [N*3-1:0]   req_op;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    alu_share_arb #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: {result, err}
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return {a + b, 1'b0};
            3'd1:    return {a - b, 1'b0};
            3'd2:    return {a & b, 1'b0};
            3'd3:    return {a | b, 1'b0};
            3'd4:    return {a ^ b, 1'b0};
            default: return {32'hDEADBEEF, 1'b1};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[3*i +: 3]  = op;
        req_valid[i]      = 1'b1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called at posedge+1 in IDLE with requests driven; expects grant to g.
    // keep: leave req_valid untouched through the op; hold: cycles of withheld rsp_ready.
    task automatic one_op(input int g, input bit keep, input int hold);
        logic [N-1:0] oh;
        logic [32:0]  m;
        exp_t         e;
        oh = N'(1) << g;
        #1;
        chk("grant", req_ready, oh);
        m = model(req_a[32*g +: 32], req_b[32*g +: 32], req_op[3*g +: 3]);
        sb.push_back('{vld: oh, data: m[32:1], err: m[0]});
        @(posedge clk); #1;
        if (!keep) req_valid = '0;
        chk("exec_ready", req_ready, '0);
        chk("exec_rspv", rsp_valid, '0);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk("rsp_valid", rsp_valid, e.vld);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
        for (int c = 0; c < hold; c++) begin
            rsp_ready = ~oh;
            req_valid = ~oh;
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, e.vld);
            chk("hold_data", rsp_data, e.data);
            chk("hold_ready", req_ready, '0);
        end
        rsp_ready = oh;
        @(posedge clk); #1;
        rsp_ready = '0;
        if (hold > 0) req_valid = '0;
        chk("ack", rsp_valid, '0);
    endtask

    initial begin
        req_a = '0; req_b = '0; req_op = '0;
        do_reset();
        chk("rst_ready", req_ready, '0);
        chk("rst_rspv", rsp_valid, '0);
        chk("rst_data", rsp_data, '0);
        chk("rst_err", rsp_err, '0);

        // single SUB from requester 0
        set_req(0, 32'd5, 32'd3, 3'b001);
        one_op(0, 1'b0, 0);

        // all requesters valid continuously, fresh pointer
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'(i), 32'd10, 3'b000);
        one_op(0, 1'b1, 0);
        one_op(1, 1'b1, 0);
        one_op(2, 1'b1, 0);
        one_op(3, 1'b1, 0);
        one_op(0, 1'b0, 0);

        // illegal opcode on requester 2 (pointer now 1)
        set_req(2, 32'd1, 32'd2, 3'b110);
        one_op(2, 1'b0, 0);

        // backpressure on requester 1 (pointer now 3, wraps to 1)
        set_req(1, 32'd7, 32'd8, 3'b000);
        one_op(1, 1'b0, 5);

        // wrap and boundary arithmetic (pointer now 2)
        set_req(0, 32'hFFFFFFFF, 32'd1, 3'b000);
        one_op(0, 1'b0, 0);
        set_req(3, 32'd0, 32'd1, 3'b001);
        one_op(3, 1'b0, 0);
        set_req(1, 32'hA5A5A5A5, 32'hFFFFFFFF, 3'b100);
        one_op(1, 1'b0, 0);
        set_req(2, 32'hF0F0F0F0, 32'h0FF00FF0, 3'b010);
        one_op(2, 1'b0, 0);
        set_req(3, 32'hF0000000, 32'h0000000F, 3'b011);
        one_op(3, 1'b0, 0);

        // reset while in EXEC aborts the op (pointer now 0 -> grant 1 after this)
        set_req(1, 32'd9, 32'd9, 3'b000);
        #1 chk("pre_abort_grant", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", req_ready, '0);
        chk("abort_rspv", rsp_valid, '0);
        chk("abort_data", rsp_data, '0);
        chk("abort_err", rsp_err, '0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", rsp_valid, '0);
        end
        set_req(1, 32'd100, 32'd1, 3'b001);
        set_req(3, 32'd200, 32'd2, 3'b000);
        one_op(1, 1'b0, 0);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
